// File: rtl/c3lib_ckdiv_pkg.sv
// Shared types and helpers for the c3lib programmable clock divider.
package c3lib_ckdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } ckdiv_state_e;

    localparam int unsigned CKDIV_MIN_RATIO = 2;

    // High-phase length of a period of ratio n: the extra cycle of odd ratios goes high.
    function automatic logic [31:0] ckdiv_hi_cnt(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/c3lib_ckdiv_prog.sv
// Programmable integer clock divider with glitch-free start/stop and
// ratio changes applied only at period boundaries.
module c3lib_ckdiv_prog
    import c3lib_ckdiv_pkg::*;
#(
    parameter int unsigned DIV_W         = 8,
    parameter int unsigned DEFAULT_RATIO = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             ratio_req,
    output logic             ratio_ack,
    output logic             clk_div_out,
    output logic             period_strobe,
    output logic             div_active
);

    ckdiv_state_e     state_r;
    ckdiv_state_e     state_nxt_s;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic [DIV_W-1:0] r_act_r;
    logic [DIV_W-1:0] r_nxt_s;
    logic [DIV_W-1:0] pend_ratio_r;
    logic             pend_vld_r;
    logic [DIV_W-1:0] req_ratio_s;
    logic [DIV_W-1:0] hi_s;
    logic             wrap_s;
    logic             bnd_s;
    logic             ack_nxt_s;
    logic             out_nxt_s;

    // Request clamp, period-end detect and next counter/state decision.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        bnd_s       = 1'b0;
        req_ratio_s = (div_ratio < DIV_W'(CKDIV_MIN_RATIO)) ? DIV_W'(CKDIV_MIN_RATIO) : div_ratio;
        wrap_s      = (cnt_r == (r_act_r - DIV_W'(1)));
        case (state_r)
            IDLE: begin
                if (div_en) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = '0;
                    bnd_s       = 1'b1;
                end else begin
                    cnt_nxt_s   = '0;
                end
            end
            RUN: begin
                state_nxt_s = div_en ? RUN : STOP;
                if (wrap_s) begin
                    cnt_nxt_s = '0;
                    bnd_s     = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + DIV_W'(1);
                end
            end
            STOP: begin
                if (div_en) begin
                    state_nxt_s = RUN;
                    if (wrap_s) begin
                        cnt_nxt_s = '0;
                        bnd_s     = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + DIV_W'(1);
                    end
                end else if (wrap_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + DIV_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Ratio in force for the next cycle; a request coinciding with a boundary wins over the pending one.
    always_comb begin
        if (bnd_s && ratio_req) begin
            r_nxt_s = req_ratio_s;
        end else if (bnd_s && pend_vld_r) begin
            r_nxt_s = pend_ratio_r;
        end else begin
            r_nxt_s = r_act_r;
        end
        ack_nxt_s = bnd_s && (ratio_req || pend_vld_r);
        hi_s      = DIV_W'(ckdiv_hi_cnt(32'(r_nxt_s)));
        out_nxt_s = (state_nxt_s != IDLE) && (cnt_nxt_s < hi_s);
    end

    // Divider state, ratio bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            r_act_r       <= DIV_W'(DEFAULT_RATIO);
            pend_ratio_r  <= DIV_W'(DEFAULT_RATIO);
            pend_vld_r    <= 1'b0;
            ratio_ack     <= 1'b0;
            clk_div_out   <= 1'b0;
            period_strobe <= 1'b0;
            div_active    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            r_act_r       <= r_nxt_s;
            ratio_ack     <= ack_nxt_s;
            clk_div_out   <= out_nxt_s;
            period_strobe <= bnd_s;
            div_active    <= (state_nxt_s != IDLE);
            if (bnd_s) begin
                pend_vld_r   <= 1'b0;
            end else if (ratio_req) begin
                pend_ratio_r <= req_ratio_s;
                pend_vld_r   <= 1'b1;
            end else begin
                pend_vld_r   <= pend_vld_r;
            end
        end
    end

endmodule
